// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the multi-cycle CPU's single shared memory port.
// Data accesses win arbitration; a bounded grant streak keeps fetch moving.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t state, state_nx;

  logic          if_elig, dm_elig, if_grant, dm_grant, mem_done;
  logic [SW-1:0] streak, streak_nx;
  logic          mem_req_nx, mem_we_nx, if_done_nx, dm_done_nx, busy_nx, owner_nx;
  logic [31:0]   mem_addr_nx, mem_wdata_nx, if_rdata_nx, dm_rdata_nx;

  // A requester whose done is still high is finishing, not asking again.
  always_comb begin
    if_elig  = if_req & ~if_done;
    dm_elig  = dm_req & ~dm_done;
    dm_grant = (state == IDLE) & dm_elig & (~if_elig | (streak != LIMIT));
    if_grant = (state == IDLE) & if_elig & ~dm_grant;
    mem_done = (state != IDLE) & mem_req & mem_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dm_grant)      state_nx = DM_BUSY;
        else if (if_grant) state_nx = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    dm_rdata_nx  = dm_rdata;
    owner_nx     = owner;
    streak_nx    = streak;
    if_done_nx   = 1'b0;
    dm_done_nx   = 1'b0;
    busy_nx      = (state_nx != IDLE);
    case (state)
      IDLE: begin
        if (if_grant || !if_req)           streak_nx = '0;
        else if (dm_grant && streak != LIMIT) streak_nx = streak + SW'(1);
        if (dm_grant) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = dm_we;
          mem_addr_nx  = dm_addr & ~32'h3;
          mem_wdata_nx = dm_wdata;
          owner_nx     = 1'b1;
        end else if (if_grant) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = if_addr & ~32'h3;
          mem_wdata_nx = 32'h0;
          owner_nx     = 1'b0;
        end
      end
      default: begin
        if (mem_done) begin
          mem_req_nx = 1'b0;
          if (state == IF_BUSY) begin
            if_done_nx  = 1'b1;
            if_rdata_nx = mem_rdata;
          end else begin
            dm_done_nx = 1'b1;
            if (!mem_we) dm_rdata_nx = mem_rdata;
          end
        end
      end
    endcase
  end

  // Output and streak registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      dm_rdata  <= 32'h0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      streak    <= '0;
    end else begin
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      dm_rdata  <= dm_rdata_nx;
      if_done   <= if_done_nx;
      dm_done   <= dm_done_nx;
      busy      <= busy_nx;
      owner     <= owner_nx;
      streak    <= streak_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, random
// requesters/memory, and a few directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, dm_done, mem_req, mem_we, busy, owner;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  bit rnd = 0;
  int pct = 0;
  int spur = 0;
  int wait_cfg = 0;
  int cur_wait = 0;
  int wcnt = 0;
  logic [31:0] fix_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, and what each requester has received.
  int          m_cur;  // 0 none, 1 fetch in flight, 2 data in flight
  logic        m_if_done, m_dm_done, m_mem_req, m_mem_we, m_owner;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  int          m_streak, m_run, m_max_run, m_if_grants;
  bit          ie, de, gi, gd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cur = 0; m_if_done = 0; m_dm_done = 0; m_mem_req = 0; m_mem_we = 0;
      m_owner = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
      m_streak = 0;
    end else if (m_cur == 0) begin
      ie = if_req && !m_if_done;
      de = dm_req && !m_dm_done;
      gd = de && (!ie || m_streak < LIMIT);
      gi = ie && !gd;
      m_if_done = 0;
      m_dm_done = 0;
      if (gi || !if_req) m_streak = 0;
      else if (gd && m_streak < LIMIT) m_streak++;
      if (gd) begin
        m_cur = 2; m_mem_req = 1; m_mem_we = dm_we; m_owner = 1;
        m_addr = {dm_addr[31:2], 2'b00}; m_wdata = dm_wdata;
        m_run++;
        if (m_run > m_max_run) m_max_run = m_run;
      end else if (gi) begin
        m_cur = 1; m_mem_req = 1; m_mem_we = 0; m_owner = 0;
        m_addr = {if_addr[31:2], 2'b00}; m_wdata = 0;
        m_run = 0;
        m_if_grants++;
      end
    end else if (mem_ready) begin
      if (m_cur == 1) begin
        m_if_done = 1; m_if_rdata = mem_rdata;
      end else begin
        m_dm_done = 1;
        if (!m_mem_we) m_dm_rdata = mem_rdata;
      end
      m_mem_req = 0;
      m_cur = 0;
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("mem_req",   mem_req,   m_mem_req);
      check("mem_we",    mem_we,    m_mem_we);
      check("mem_addr",  mem_addr,  m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("if_done",   if_done,   m_if_done);
      check("dm_done",   dm_done,   m_dm_done);
      check("if_rdata",  if_rdata,  m_if_rdata);
      check("dm_rdata",  dm_rdata,  m_dm_rdata);
      check("busy",      busy,      32'(m_cur != 0));
      check("owner",     owner,     m_owner);
    end
  end

  // Memory: configurable wait states, optional spurious ready while idle
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (wcnt >= cur_wait) begin
        mem_ready = 1;
        mem_rdata = rnd ? $urandom : fix_rdata;
      end else begin
        mem_ready = 0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      cur_wait = rnd ? $urandom_range(0, 3) : wait_cfg;
      mem_ready = (spur == 2) || (spur == 1 && $urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
  end

  // Requesters: drop req in the done cycle; raise randomly when enabled
  always @(posedge clk) begin
    #2;
    if (if_req && if_done) if_req = 0;
    else if (rnd && !if_req && $urandom_range(0, 99) < pct) begin
      if_req = 1; if_addr = $urandom;
    end
    if (dm_req && dm_done) dm_req = 0;
    else if (rnd && !dm_req && $urandom_range(0, 99) < pct) begin
      dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_high(input string name, input int which);
    int n;
    n = 0;
    while (n < 60 && !((which == 0 && mem_req) || (which == 1 && if_done) ||
                       (which == 2 && dm_done))) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      errors++;
      checks++;
      $display("FAIL %s: timed out waiting, got 0 expected 1", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int cnt;

  initial begin
    rst = 0; if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0;
    dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
    tick();
    chk_en = 1;
    check("reset_mem_req", mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_owner", owner, 0);
    check("reset_mem_addr", mem_addr, 0);
    repeat (2) tick();
    #2 rst = 1;

    // Single fetch, zero-wait memory
    tick();
    fix_rdata = 32'h2002_0005; wait_cfg = 0; if_addr = 32'h0000_0013; if_req = 1;
    wait_high("fetch_grant", 0);
    check("fetch_mem_addr", mem_addr, 32'h0000_0010);
    check("fetch_mem_we", mem_we, 0);
    tick();
    check("fetch_done", if_done, 1);
    check("fetch_rdata", if_rdata, 32'h2002_0005);
    tick();
    check("fetch_done_pulse", if_done, 0);

    // Data write with 3 wait states
    repeat (2) tick();
    wait_cfg = 3; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1;
    wait_high("write_grant", 0);
    cnt = 0;
    while (mem_req && cnt < 20) begin
      cnt++;
      check("write_we_stable", mem_we, 1);
      check("write_addr_stable", mem_addr, 32'h100);
      check("write_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
      tick();
    end
    check("write_req_cycles", cnt, 4);
    check("write_done", dm_done, 1);
    check("write_rdata_kept", dm_rdata, 0);

    // Contention: data first, fetch granted in the dm_done cycle
    repeat (2) tick();
    wait_cfg = 1; fix_rdata = 32'h1111_2222;
    if_addr = 32'h40; dm_addr = 32'h83; dm_we = 0; if_req = 1; dm_req = 1;
    wait_high("cont_grant", 0);
    check("cont_first_owner", owner, 1);
    check("cont_first_addr", mem_addr, 32'h80);
    wait_high("cont_dm_done", 2);
    check("cont_dm_rdata", dm_rdata, 32'h1111_2222);
    tick();
    check("cont_if_req", mem_req, 1);
    check("cont_if_owner", owner, 0);
    check("cont_if_addr", mem_addr, 32'h40);
    wait_high("cont_if_done", 1);
    check("cont_if_rdata", if_rdata, 32'h1111_2222);

    // Spurious mem_ready while idle
    repeat (2) tick();
    spur = 2;
    repeat (5) begin
      tick();
      check("spur_busy", busy, 0);
      check("spur_done", 32'(if_done | dm_done), 0);
    end
    spur = 0;

    // Reset in the middle of a data read
    tick();
    wait_cfg = 50; dm_we = 0; dm_addr = 32'h200; dm_req = 1;
    wait_high("rst_grant", 0);
    tick();
    #2 rst = 0;
    #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_dm_done", dm_done, 0);
    dm_req = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    wait_cfg = 0;
    repeat (4) begin
      tick();
      check("rst_after_done", dm_done, 0);
      check("rst_after_busy", busy, 0);
    end

    // Both requesters always asking: fetch must keep progressing
    m_run = 0; m_max_run = 0; m_if_grants = 0;
    rnd = 1; pct = 100;
    repeat (300) tick();
    check("starve_run_bound", 32'(m_max_run <= LIMIT), 1);
    check("starve_if_progress", 32'(m_if_grants > 20), 1);

    // Random traffic with random waits and spurious ready
    pct = 30; spur = 1;
    repeat (3000) tick();
    rnd = 0; spur = 0;
    cnt = 0;
    while ((if_req || dm_req || busy) && cnt < 100) begin
      tick();
      cnt++;
    end
    check("drain_idle", 32'(if_req || dm_req || busy), 0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
